adc_scan_sched: RTL and testbench
=================================

Name: adc_scan_sched

Overview:
- Sequences the SPI ADC conversion engine: 12-bit result, 3-bit channel select, start/done handshake.
- Sweeps enabled channels round-robin once per sample period. Stores the latest result per channel.
- Lets a host (motor/line-follow logic) insert on-demand single-channel reads, which take priority at the next issue slot.
- Sits between the ADC engine and all sensor consumers; the engine is never driven by anyone else.

Parameters:
- NUM_CH, 8, number of ADC channels (3-bit select).
- PERIOD_CYCLES, 48000, clk cycles between sweep starts (1 kHz at 48 MHz).
- TIMEOUT_CYCLES, 2048, max clk cycles from conv_start to conv_done before abort.

Ports:
- clk  in  1  system clock (48 MHz internal oscillator)
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = periodic sweeps run; 0 = sweeps stop after the current conversion
- ch_mask  in  8  per-channel sweep enable
- req_valid  in  1  on-demand read request
- req_ch  in  3  requested channel
- req_ready  out  1  request accepted this cycle (valid&ready handshake)
- rsp_valid  out  1  1-cycle pulse: on-demand result available
- rsp_data  out  12  on-demand result, held until next rsp_valid
- conv_start  out  1  1-cycle pulse to ADC engine
- conv_ch  out  3  channel for conversion, stable from conv_start to conv_done
- conv_busy  in  1  engine busy
- conv_done  in  1  1-cycle pulse, conv_data valid
- conv_data  in  12  conversion result
- result_flat  out  96  channel k result at bits [12k+11:12k]
- result_valid  out  8  channel k has at least one stored result
- sweep_done  out  1  1-cycle pulse when a sweep completes
- timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset (rst=0, async): state IDLE; period counter 0; scan pointer 0; all outputs 0 (result_flat, result_valid, rsp_data, conv_ch, timeout_err included).
- Period counter runs while enable=1. It wraps at PERIOD_CYCLES-1 and sets sweep_pending. A tick while a sweep is still running is dropped (no queueing).
- States:
  - IDLE: if req_valid → ISSUE (demand). Else if sweep_pending and ch_mask≠0 → find the lowest set mask bit ≥ pointer → ISSUE (sweep). If ch_mask=0, clear sweep_pending and pulse sweep_done.
  - ISSUE: wait for conv_busy=0, then pulse conv_start with conv_ch latched → WAIT_DONE. req_ready=1 only in the cycle a demand request is issued.
  - WAIT_DONE: on conv_done → STORE. If the timeout counter reaches TIMEOUT_CYCLES first → set timeout_err and treat as done with no store. A demand request that times out gives no rsp_valid.
  - STORE: demand → rsp_data<=conv_data, rsp_valid pulse. Sweep → write slot, set result_valid[ch], advance pointer to the next set mask bit above the current one. If none remains, pulse sweep_done, clear sweep_pending, reset pointer to 0. → IDLE.
- Priority: a pending demand wins over the next sweep channel at every IDLE visit. A sweep in progress resumes afterwards at the same pointer.
- ch_mask is sampled at each pointer advance. Bits cleared mid-sweep are skipped; results already stored are retained.
- enable=0 mid-sweep: the current conversion completes and stores, then the sweep is abandoned. sweep_pending is cleared, pointer goes to 0, no sweep_done. Demand requests are still served.
- conv_done outside WAIT_DONE is ignored.
- Latency: demand request accepted in IDLE with engine idle → conv_start 2 cycles after req_valid is sampled. rsp_valid 1 cycle after conv_done.
- Only rst clears timeout_err.

Decomposition:
- Shared package sensor_pkg: ADC_W=12, CH_W=3, NUM_CH, the state enum, and the CLK_HZ constant.
- One sub-module, adc_next_ch: combinational find-next-set-bit over ch_mask from the pointer, with a found flag.
- The timers stay inline.

Test Plan:
- Reset then enable=1, ch_mask=8'h05, engine model returns 12'h100+ch: exactly two conversions (ch0, ch2). Slots 0/2 = 100/102, result_valid=8'h05, one sweep_done pulse.
- Demand req_ch=5 asserted while sweep on ch0 is converting: ch0 stores first, then conv_ch=5, rsp_valid with 12'h105, then the sweep resumes at ch2.
- Engine never returns conv_done: timeout_err=1 at TIMEOUT_CYCLES, FSM back to IDLE, the next channel is issued, the slot stays unchanged.
- ch_mask=0 with enable=1: no conv_start ever; sweep_done pulses once per PERIOD_CYCLES.
- rst asserted mid-WAIT_DONE: all outputs 0 immediately. After release, the late conv_done is ignored and the first conv_start follows the next period tick.
- enable dropped during ch1 of mask 8'h07: ch1 stores, ch2 is never issued, no sweep_done.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared sensor-side constants and the ADC scan scheduler state type.
package sensor_pkg;

    localparam int unsigned CLK_HZ = 48_000_000;
    localparam int unsigned ADC_W  = 12;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned NUM_CH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/adc_next_ch.sv
// Finds the lowest set mask bit at or above a start index (start may be NUM_CH: nothing found).
module adc_next_ch
    import sensor_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W:0]     i_from,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_found
);

    // Scan downward so the lowest qualifying bit is the last one kept.
    always_comb begin
        o_ch    = '0;
        o_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            o_ch    = (i_mask[i] && ((CH_W + 1)'(i) >= i_from)) ? CH_W'(i) : o_ch;
            o_found = (i_mask[i] && ((CH_W + 1)'(i) >= i_from)) ? 1'b1     : o_found;
        end
    end

endmodule

// File: rtl/adc_scan_sched.sv
// ADC scan scheduler: periodic round-robin sweeps of masked channels plus
// prioritised on-demand single reads, with a conversion timeout.
module adc_scan_sched
    import sensor_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = CLK_HZ / 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    input  logic                     i_req_valid,
    input  logic [CH_W-1:0]          i_req_ch,
    output logic                     o_req_ready,
    output logic                     o_rsp_valid,
    output logic [ADC_W-1:0]         o_rsp_data,
    output logic                     o_conv_start,
    output logic [CH_W-1:0]          o_conv_ch,
    input  logic                     i_conv_busy,
    input  logic                     i_conv_done,
    input  logic [ADC_W-1:0]         i_conv_data,
    output logic [NUM_CH*ADC_W-1:0]  o_result_flat,
    output logic [NUM_CH-1:0]        o_result_valid,
    output logic                     o_sweep_done,
    output logic                     o_timeout_err
);

    localparam int unsigned PW = $clog2(PERIOD_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    sched_state_t                   r_state;
    logic [PW-1:0]                  r_period_cnt;
    logic [TW-1:0]                  r_tmo_cnt;
    logic                           r_sweep_pend;
    logic                           r_is_demand;
    logic [CH_W-1:0]                r_ch;
    logic [CH_W-1:0]                r_ptr;
    logic [NUM_CH-1:0][ADC_W-1:0]   r_result;

    logic                           w_tick;
    logic [CH_W:0]                  w_search_from;
    logic [CH_W-1:0]                w_next_ch;
    logic                           w_next_found;

    assign w_tick        = i_enable && (r_period_cnt == PW'(PERIOD_CYCLES - 1));
    assign o_conv_ch     = r_ch;
    assign o_result_flat = r_result;

    // In STORE look past the channel just converted; otherwise resume from the pointer.
    always_comb begin
        if (r_state == S_STORE) begin
            w_search_from = {1'b0, r_ch} + (CH_W + 1)'(1);
        end else begin
            w_search_from = {1'b0, r_ptr};
        end
    end

    adc_next_ch u_next_ch (
        .i_mask  (i_ch_mask),
        .i_from  (w_search_from),
        .o_ch    (w_next_ch),
        .o_found (w_next_found)
    );

    // Sample-period counter; held at zero while sweeps are disabled.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_period_cnt <= '0;
        end else if (!i_enable || w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PW'(1);
        end
    end

    // Scheduler FSM with conversion timer, result storage and registered pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= S_IDLE;
            r_tmo_cnt      <= '0;
            r_sweep_pend   <= 1'b0;
            r_is_demand    <= 1'b0;
            r_ch           <= '0;
            r_ptr          <= '0;
            r_result       <= '0;
            o_result_valid <= '0;
            o_req_ready    <= 1'b0;
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_conv_start   <= 1'b0;
            o_sweep_done   <= 1'b0;
            o_timeout_err  <= 1'b0;
        end else begin
            o_req_ready  <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_conv_start <= 1'b0;
            o_sweep_done <= 1'b0;
            // A tick landing while a sweep is still pending is simply absorbed.
            if (w_tick) begin
                r_sweep_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!i_enable) begin
                        r_sweep_pend <= 1'b0;
                        r_ptr        <= '0;
                    end
                    if (i_req_valid) begin
                        r_is_demand <= 1'b1;
                        r_ch        <= i_req_ch;
                        r_state     <= S_ISSUE;
                    end else if (i_enable && r_sweep_pend) begin
                        if (w_next_found) begin
                            r_is_demand <= 1'b0;
                            r_ch        <= w_next_ch;
                            r_state     <= S_ISSUE;
                        end else begin
                            o_sweep_done <= 1'b1;
                            r_sweep_pend <= 1'b0;
                            r_ptr        <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!i_conv_busy) begin
                        o_conv_start <= 1'b1;
                        o_req_ready  <= r_is_demand;
                        r_tmo_cnt    <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_conv_done) begin
                        if (r_is_demand) begin
                            o_rsp_data  <= i_conv_data;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            r_result[r_ch]       <= i_conv_data;
                            o_result_valid[r_ch] <= 1'b1;
                        end
                        r_state <= S_STORE;
                    end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        o_timeout_err <= 1'b1;
                        r_state       <= S_STORE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                S_STORE: begin
                    r_state <= S_IDLE;
                    if (!r_is_demand) begin
                        if (!i_enable) begin
                            r_sweep_pend <= 1'b0;
                            r_ptr        <= '0;
                        end else if (w_next_found) begin
                            r_ptr <= w_next_ch;
                        end else begin
                            o_sweep_done <= 1'b1;
                            r_sweep_pend <= 1'b0;
                            r_ptr        <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed and randomized bench for adc_scan_sched against a transaction-level model.
`timescale 1ns/1ps
module tb_adc_scan_sched;

    localparam int unsigned PERIOD = 200;
    localparam int unsigned TMO    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  ch_mask;
    logic        req_valid;
    logic [2:0]  req_ch;
    logic        req_ready;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        conv_start;
    logic [2:0]  conv_ch;
    logic        conv_busy = 1'b0;
    logic        conv_done = 1'b0;
    logic [11:0] conv_data = 12'h000;
    logic [95:0] result_flat;
    logic [7:0]  result_valid;
    logic        sweep_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Engine model / monitor state (written only by the engine process)
    int          cyc = 0;
    int          sd_cnt = 0;
    int          rsp_cnt = 0;
    logic [11:0] rsp_last = 12'h000;
    logic [2:0]  log_ch[$];
    logic [11:0] log_data[$];
    int          e_cnt = 0;
    logic [2:0]  e_ch = 3'd0;
    int          hang_served = 0;

    // Engine configuration (written only by the stimulus process)
    int          lat_cfg = 4;
    bit          lat_rand = 1'b0;
    bit          rand_data = 1'b0;
    int          hang_req = 0;
    logic [11:0] base = 12'h100;

    // Reference model of the stored results
    logic [11:0] exp_res [8];
    logic [7:0]  exp_valid;

    always #5 clk = ~clk;

    adc_scan_sched #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_enable       (enable),
        .i_ch_mask      (ch_mask),
        .i_req_valid    (req_valid),
        .i_req_ch       (req_ch),
        .o_req_ready    (req_ready),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_data     (rsp_data),
        .o_conv_start   (conv_start),
        .o_conv_ch      (conv_ch),
        .i_conv_busy    (conv_busy),
        .i_conv_done    (conv_done),
        .i_conv_data    (conv_data),
        .o_result_flat  (result_flat),
        .o_result_valid (result_valid),
        .o_sweep_done   (sweep_done),
        .o_timeout_err  (timeout_err)
    );

    // ADC engine model and output monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (sweep_done) sd_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_last = rsp_data;
        end
        conv_done = 1'b0;
        if (conv_start) begin
            log_ch.push_back(conv_ch);
            e_ch = conv_ch;
            if (hang_served < hang_req) begin
                hang_served++;
                conv_busy = 1'b0;
            end else begin
                conv_busy = 1'b1;
                e_cnt = lat_rand ? int'($urandom_range(2, 8)) : lat_cfg;
            end
        end else if (conv_busy) begin
            e_cnt--;
            if (e_cnt <= 0) begin
                conv_busy = 1'b0;
                conv_done = 1'b1;
                conv_data = rand_data ? 12'($urandom) : base + {9'd0, e_ch};
                log_data.push_back(conv_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=no-event expected=event-within-budget", tag);
    endtask

    task automatic wait_sd(input string tag, input int budget);
        int s0;
        int n;
        s0 = sd_cnt;
        n = 0;
        while (sd_cnt == s0 && n < budget) begin
            tick(1);
            n++;
        end
        if (sd_cnt == s0) bound_fail(tag);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int r0;
        int n;
        r0 = rsp_cnt;
        n = 0;
        while (rsp_cnt == r0 && n < budget) begin
            tick(1);
            n++;
        end
        if (rsp_cnt == r0) bound_fail(tag);
    endtask

    task automatic wait_start_ch(input string tag, input logic [2:0] ch, input int budget);
        int n;
        n = 0;
        while (!(conv_start && conv_ch == ch) && n < budget) begin
            tick(1);
            n++;
        end
        if (!(conv_start && conv_ch == ch)) bound_fail(tag);
    endtask

    task automatic do_demand(input string tag, input logic [2:0] ch, output int n);
        req_valid = 1'b1;
        req_ch    = ch;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) bound_fail(tag);
        req_valid = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) exp_res[i] = 12'h000;
        exp_valid = 8'h00;
    endtask

    task automatic model_store(input int ch, input logic [11:0] data);
        exp_res[ch]   = data;
        exp_valid[ch] = 1'b1;
    endtask

    task automatic check_results(input string tag);
        logic [95:0] flat;
        for (int i = 0; i < 8; i++) flat[12*i +: 12] = exp_res[i];
        chk({tag, "_result_flat"}, result_flat, flat);
        chk({tag, "_result_valid"}, {88'd0, result_valid}, {88'd0, exp_valid});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_conv_start"}, {95'd0, conv_start}, 96'd0);
        chk({tag, "_conv_ch"}, {93'd0, conv_ch}, 96'd0);
        chk({tag, "_req_ready"}, {95'd0, req_ready}, 96'd0);
        chk({tag, "_rsp_valid"}, {95'd0, rsp_valid}, 96'd0);
        chk({tag, "_rsp_data"}, {84'd0, rsp_data}, 96'd0);
        chk({tag, "_result_flat"}, result_flat, 96'd0);
        chk({tag, "_result_valid"}, {88'd0, result_valid}, 96'd0);
        chk({tag, "_sweep_done"}, {95'd0, sweep_done}, 96'd0);
        chk({tag, "_timeout_err"}, {95'd0, timeout_err}, 96'd0);
    endtask

    initial begin
        int          l0;
        int          s0;
        int          r0;
        int          d0;
        int          n;
        int          cs;
        int          k;
        logic [7:0]  m;
        logic [2:0]  c;

        rst_n = 1'b0; enable = 1'b0; ch_mask = 8'h00; req_valid = 1'b0; req_ch = 3'd0;
        model_clear();
        tick(3);
        check_zero("reset");

        // Basic sweep over channels 0 and 2
        rst_n = 1'b1; enable = 1'b1; ch_mask = 8'h05;
        l0 = log_ch.size(); s0 = sd_cnt;
        wait_sd("t1_sweep_done", 1000);
        chk("t1_nconv", log_ch.size() - l0, 2);
        chk("t1_first_ch", {93'd0, log_ch[l0]}, 0);
        chk("t1_second_ch", {93'd0, log_ch[l0 + 1]}, 2);
        model_store(0, 12'h100);
        model_store(2, 12'h102);
        check_results("t1");
        tick(20);
        chk("t1_sweep_done_once", sd_cnt - s0, 1);

        // Demand for ch5 raised while ch0 of the next sweep converts
        l0 = log_ch.size(); r0 = rsp_cnt;
        wait_start_ch("t2_wait_ch0", 3'd0, 600);
        do_demand("t2_req_ready", 3'd5, n);
        wait_rsp("t2_rsp_valid", 200);
        chk("t2_rsp_data", {84'd0, rsp_last}, 12'h105);
        wait_sd("t2_sweep_done", 400);
        chk("t2_nconv", log_ch.size() - l0, 3);
        chk("t2_order0", {93'd0, log_ch[l0]}, 0);
        chk("t2_order1", {93'd0, log_ch[l0 + 1]}, 5);
        chk("t2_order2", {93'd0, log_ch[l0 + 2]}, 2);
        chk("t2_rsp_count", rsp_cnt - r0, 1);
        check_results("t2");

        // Engine never answers ch0: timeout, then ch2 proceeds normally
        base = 12'h200; hang_req = hang_req + 1;
        l0 = log_ch.size();
        wait_start_ch("t3_wait_ch0", 3'd0, 600);
        cs = cyc;
        chk("t3_tmo_before", {95'd0, timeout_err}, 0);
        n = 0;
        while (!timeout_err && n < int'(TMO) + 20) begin
            tick(1);
            n++;
        end
        if (!timeout_err) bound_fail("t3_timeout_err");
        chk("t3_tmo_cycles", cyc - cs, TMO);
        wait_sd("t3_sweep_done", 400);
        chk("t3_nconv", log_ch.size() - l0, 2);
        chk("t3_next_ch", {93'd0, log_ch[l0 + 1]}, 2);
        chk("t3_tmo_sticky", {95'd0, timeout_err}, 1);
        model_store(2, 12'h202);
        check_results("t3");

        // Empty mask: only sweep_done pulses, one per period
        ch_mask = 8'h00;
        l0 = log_ch.size(); s0 = sd_cnt;
        tick(3 * PERIOD);
        chk("t4_sweep_done_count", sd_cnt - s0, 3);
        chk("t4_no_conv", log_ch.size() - l0, 0);

        // Reset in the middle of a conversion
        ch_mask = 8'h05; base = 12'h300; lat_cfg = 20;
        wait_start_ch("t5_wait_ch0", 3'd0, 600);
        tick(3);
        #2 rst_n = 1'b0;
        #1 check_zero("t5_rst");
        model_clear();
        tick(2);
        rst_n = 1'b1;
        cs = cyc; l0 = log_ch.size();
        tick(50);
        chk("t5_quiet_no_conv", log_ch.size() - l0, 0);
        check_results("t5_quiet");
        n = 0;
        while (log_ch.size() == l0 && n < 400) begin
            tick(1);
            n++;
        end
        if (log_ch.size() == l0) bound_fail("t5_first_start");
        chk("t5_first_start_after_tick", {95'd0, (cyc - cs >= int'(PERIOD)) && (cyc - cs <= int'(PERIOD) + 4)}, 1);
        wait_sd("t5_sweep_done", 600);
        model_store(0, 12'h300);
        model_store(2, 12'h302);
        check_results("t5");

        // Enable dropped while ch1 converts: sweep abandoned silently
        ch_mask = 8'h07; base = 12'h400; lat_cfg = 6;
        l0 = log_ch.size(); s0 = sd_cnt;
        wait_start_ch("t6_wait_ch1", 3'd1, 600);
        enable = 1'b0;
        tick(300);
        chk("t6_no_sweep_done", sd_cnt - s0, 0);
        chk("t6_nconv", log_ch.size() - l0, 2);
        chk("t6_second_ch", {93'd0, log_ch[l0 + 1]}, 1);
        model_store(0, 12'h400);
        model_store(1, 12'h401);
        check_results("t6");
        do_demand("t6_req_ready", 3'd3, n);
        chk("t6_demand_latency", n, 2);
        chk("t6_demand_start", {95'd0, conv_start}, 1);
        wait_rsp("t6_rsp_valid", 200);
        chk("t6_rsp_data", {84'd0, rsp_last}, 12'h403);
        check_results("t6_after_demand");

        // Randomized sweeps and demands
        lat_rand = 1'b1; rand_data = 1'b1; enable = 1'b1;
        for (int it = 0; it < 6; it++) begin
            m = 8'($urandom_range(1, 255));
            ch_mask = m;
            l0 = log_ch.size(); d0 = log_data.size();
            wait_sd($sformatf("rnd%0d_sweep_done", it), 1200);
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    chk($sformatf("rnd%0d_ch%0d", it, k), {93'd0, log_ch[l0 + k]}, i);
                    model_store(i, log_data[d0 + k]);
                    k++;
                end
            end
            chk($sformatf("rnd%0d_nconv", it), log_ch.size() - l0, k);
            check_results($sformatf("rnd%0d", it));
            c = 3'($urandom_range(0, 7));
            l0 = log_ch.size(); d0 = log_data.size();
            do_demand($sformatf("rnd%0d_req_ready", it), c, n);
            wait_rsp($sformatf("rnd%0d_rsp_valid", it), 200);
            chk($sformatf("rnd%0d_demand_ch", it), {93'd0, log_ch[l0]}, {93'd0, c});
            chk($sformatf("rnd%0d_rsp_data", it), {84'd0, rsp_last}, {84'd0, log_data[d0]});
            check_results($sformatf("rnd%0d_after_demand", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
